// File: rtl/os_receiver.sv
// os_receiver: receive-side ordered-set parser.
// Classifies SKP / EIOS from single-beat sets and TS1 / TS2 from four-beat
// sets across all lanes, keeps the last good TS per lane, and tracks runs of
// identical TS sets and of logical-IDLE beats for the LTSSM.
module os_receiver #(
    parameter int MAX_NUM_LANES = 4,
    parameter int DATA_WIDTH    = 32,
    parameter int KEEP_WIDTH    = DATA_WIDTH/8,
    parameter int USER_WIDTH    = 4
) (
    input  logic                                  clk_i,
    input  logic                                  rst_n_i,
    input  logic [DATA_WIDTH*MAX_NUM_LANES-1:0]   s_axis_tdata,
    input  logic [KEEP_WIDTH*MAX_NUM_LANES-1:0]   s_axis_tkeep,
    input  logic                                  s_axis_tvalid,
    input  logic                                  s_axis_tlast,
    input  logic [USER_WIDTH*MAX_NUM_LANES-1:0]   s_axis_tuser,
    output logic                                  s_axis_tready,
    output logic                                  os_valid_o,
    output logic                                  ts1_det_o,
    output logic                                  ts2_det_o,
    output logic                                  eios_det_o,
    output logic                                  skp_det_o,
    output logic [128*MAX_NUM_LANES-1:0]          ts_lane_o,
    output logic [7:0]                            consec_cnt_o,
    output logic [7:0]                            idle_cnt_o,
    output logic                                  os_err_o
);

    // state      | meaning
    // ST_IDLE    | waiting for a COM; SKP/EIOS decoded here, IDLE beats counted
    // ST_COLLECT | storing beats 1..3 of a TS into the lane buffers
    // ST_CHECK   | one cycle: classify buffered TS, update outputs
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_CHECK   = 2'd2
    } state_t;

    localparam int LANES = MAX_NUM_LANES;
    localparam int SYMS  = DATA_WIDTH/8;
    localparam int SET_W = 128;

    localparam logic [7:0] SYM_COM = 8'hBC;
    localparam logic [7:0] SYM_SKP = 8'h1C;
    localparam logic [7:0] SYM_IDL = 8'h7C;
    localparam logic [7:0] TS1_ID  = 8'h4A;
    localparam logic [7:0] TS2_ID  = 8'h45;

    state_t                   state_q;
    logic [1:0]               beat_cnt_q;
    logic [SET_W*LANES-1:0]   buf_q;
    logic [LANES-1:0]         kerr_q;
    logic                     ready_q;
    logic                     prev_vld_q;

    logic                     beat_acc;
    logic                     lane0_com;
    logic                     all_skp;
    logic                     all_eios;
    logic                     all_idle;
    logic [LANES-1:0]         beat_kid;
    logic [7:0]               sym_b;
    logic                     k_b;

    logic [LANES-1:0]         lane_ts1;
    logic [LANES-1:0]         lane_ts2;
    logic                     all_ts1;
    logic                     all_ts2;
    logic                     same_prev;
    logic [7:0]               sym_c;
    logic [7:0]               consec_inc;

    // An all-zero keep beat is treated as if it never arrived.
    assign beat_acc      = s_axis_tvalid & ready_q & (|s_axis_tkeep);
    assign s_axis_tready = ready_q;

    // Decode the beat currently on the bus.
    always_comb begin
        lane0_com = (s_axis_tdata[7:0] == SYM_COM) && s_axis_tuser[0];
        all_skp   = 1'b1;
        all_eios  = 1'b1;
        all_idle  = 1'b1;
        beat_kid  = '0;
        sym_b     = '0;
        k_b       = 1'b0;
        for (int i = 0; i < LANES; i++) begin
            for (int j = 0; j < SYMS; j++) begin
                sym_b = s_axis_tdata[DATA_WIDTH*i + 8*j +: 8];
                k_b   = s_axis_tuser[USER_WIDTH*i + j];
                if (j == 0) begin
                    if (!(sym_b == SYM_COM && k_b)) begin
                        all_skp  = 1'b0;
                        all_eios = 1'b0;
                    end
                end else begin
                    if (!(sym_b == SYM_SKP && k_b)) all_skp  = 1'b0;
                    if (!(sym_b == SYM_IDL && k_b)) all_eios = 1'b0;
                end
                if (sym_b != 8'h00 || k_b) all_idle = 1'b0;
                // A K flag anywhere in the identifier field (sym 6..15) spoils the TS.
                if (k_b && (SYMS*int'(beat_cnt_q) + j >= 6)) beat_kid[i] = 1'b1;
            end
        end
    end

    // Classify the buffered set: sym 6..15 of every lane must be one identifier.
    always_comb begin
        lane_ts1 = '1;
        lane_ts2 = '1;
        sym_c    = '0;
        for (int i = 0; i < LANES; i++) begin
            if (kerr_q[i]) begin
                lane_ts1[i] = 1'b0;
                lane_ts2[i] = 1'b0;
            end
            for (int s = 6; s < 16; s++) begin
                sym_c = buf_q[SET_W*i + 8*s +: 8];
                if (sym_c != TS1_ID) lane_ts1[i] = 1'b0;
                if (sym_c != TS2_ID) lane_ts2[i] = 1'b0;
            end
        end
        all_ts1    = &lane_ts1;
        all_ts2    = &lane_ts2;
        // Lane 0 of the held TS is by construction the previous good TS.
        same_prev  = prev_vld_q && (buf_q[SET_W-1:8] == ts_lane_o[SET_W-1:8]);
        consec_inc = (consec_cnt_o == 8'hFF) ? 8'hFF : consec_cnt_o + 8'd1;
    end

    // Main FSM with registered pulse and counter outputs.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q      <= ST_IDLE;
            beat_cnt_q   <= '0;
            buf_q        <= '0;
            kerr_q       <= '0;
            ready_q      <= 1'b0;
            prev_vld_q   <= 1'b0;
            os_valid_o   <= 1'b0;
            ts1_det_o    <= 1'b0;
            ts2_det_o    <= 1'b0;
            eios_det_o   <= 1'b0;
            skp_det_o    <= 1'b0;
            os_err_o     <= 1'b0;
            ts_lane_o    <= '0;
            consec_cnt_o <= '0;
            idle_cnt_o   <= '0;
        end else begin
            ready_q    <= 1'b1;
            os_valid_o <= 1'b0;
            ts1_det_o  <= 1'b0;
            ts2_det_o  <= 1'b0;
            eios_det_o <= 1'b0;
            skp_det_o  <= 1'b0;
            os_err_o   <= 1'b0;

            case (state_q)
                ST_IDLE: begin
                    if (beat_acc) begin
                        if (!lane0_com) begin
                            if (all_idle) begin
                                if (idle_cnt_o != 8'hFF) idle_cnt_o <= idle_cnt_o + 8'd1;
                            end else begin
                                idle_cnt_o <= '0;
                            end
                        end else begin
                            idle_cnt_o <= '0;
                            if (all_skp && s_axis_tlast) begin
                                os_valid_o <= 1'b1;
                                skp_det_o  <= 1'b1;
                            end else if (all_eios && s_axis_tlast) begin
                                os_valid_o <= 1'b1;
                                eios_det_o <= 1'b1;
                            end else if (s_axis_tlast) begin
                                // single-beat COM set that is neither SKP nor EIOS
                                os_err_o     <= 1'b1;
                                consec_cnt_o <= '0;
                            end else begin
                                for (int i = 0; i < LANES; i++) begin
                                    buf_q[SET_W*i +: DATA_WIDTH] <= s_axis_tdata[DATA_WIDTH*i +: DATA_WIDTH];
                                end
                                kerr_q     <= '0;
                                beat_cnt_q <= 2'd1;
                                state_q    <= ST_COLLECT;
                            end
                        end
                    end
                end

                ST_COLLECT: begin
                    if (beat_acc) begin
                        for (int i = 0; i < LANES; i++) begin
                            buf_q[SET_W*i + DATA_WIDTH*int'(beat_cnt_q) +: DATA_WIDTH]
                                <= s_axis_tdata[DATA_WIDTH*i +: DATA_WIDTH];
                            if (beat_kid[i]) kerr_q[i] <= 1'b1;
                        end
                        if (beat_cnt_q == 2'd3) begin
                            beat_cnt_q <= '0;
                            if (s_axis_tlast) begin
                                state_q <= ST_CHECK;
                            end else begin
                                os_err_o     <= 1'b1;
                                consec_cnt_o <= '0;
                                state_q      <= ST_IDLE;
                            end
                        end else if (s_axis_tlast) begin
                            os_err_o     <= 1'b1;
                            consec_cnt_o <= '0;
                            beat_cnt_q   <= '0;
                            state_q      <= ST_IDLE;
                        end else begin
                            beat_cnt_q <= beat_cnt_q + 2'd1;
                        end
                    end
                end

                ST_CHECK: begin
                    state_q    <= ST_IDLE;
                    beat_cnt_q <= '0;
                    if (beat_acc || !(all_ts1 || all_ts2)) begin
                        // a beat landing during the check cycle, or a bad/mixed set
                        os_err_o     <= 1'b1;
                        consec_cnt_o <= '0;
                    end else begin
                        ts_lane_o    <= buf_q;
                        prev_vld_q   <= 1'b1;
                        os_valid_o   <= 1'b1;
                        ts1_det_o    <= all_ts1;
                        ts2_det_o    <= all_ts2;
                        consec_cnt_o <= same_prev ? consec_inc : 8'd1;
                    end
                end

                default: begin
                    state_q    <= ST_IDLE;
                    beat_cnt_q <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_os_receiver.sv
// tb_os_receiver: directed-vector bench for os_receiver.
module tb_os_receiver;

    localparam int LANES = 4;

    logic                 clk_i = 1'b0;
    logic                 rst_n_i;
    logic [32*LANES-1:0]  s_axis_tdata;
    logic [4*LANES-1:0]   s_axis_tkeep;
    logic                 s_axis_tvalid;
    logic                 s_axis_tlast;
    logic [4*LANES-1:0]   s_axis_tuser;
    logic                 s_axis_tready;
    logic                 os_valid_o;
    logic                 ts1_det_o;
    logic                 ts2_det_o;
    logic                 eios_det_o;
    logic                 skp_det_o;
    logic [128*LANES-1:0] ts_lane_o;
    logic [7:0]           consec_cnt_o;
    logic [7:0]           idle_cnt_o;
    logic                 os_err_o;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk_i = ~clk_i;

    os_receiver #(
        .MAX_NUM_LANES(LANES),
        .DATA_WIDTH   (32),
        .KEEP_WIDTH   (4),
        .USER_WIDTH   (4)
    ) dut (
        .clk_i        (clk_i),
        .rst_n_i      (rst_n_i),
        .s_axis_tdata (s_axis_tdata),
        .s_axis_tkeep (s_axis_tkeep),
        .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tlast (s_axis_tlast),
        .s_axis_tuser (s_axis_tuser),
        .s_axis_tready(s_axis_tready),
        .os_valid_o   (os_valid_o),
        .ts1_det_o    (ts1_det_o),
        .ts2_det_o    (ts2_det_o),
        .eios_det_o   (eios_det_o),
        .skp_det_o    (skp_det_o),
        .ts_lane_o    (ts_lane_o),
        .consec_cnt_o (consec_cnt_o),
        .idle_cnt_o   (idle_cnt_o),
        .os_err_o     (os_err_o)
    );

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Full TS set: link 00, lane number i, given N_FTS, rate 02, control 00, id in sym 6..15.
    function automatic logic [511:0] mk_ts(input logic [7:0] id, input logic [7:0] nfts);
        logic [511:0] r;
        r = '0;
        for (int i = 0; i < LANES; i++) begin
            r[128*i +  0 +: 8] = 8'hBC;
            r[128*i +  8 +: 8] = 8'h00;
            r[128*i + 16 +: 8] = 8'(i);
            r[128*i + 24 +: 8] = nfts;
            r[128*i + 32 +: 8] = 8'h02;
            r[128*i + 40 +: 8] = 8'h00;
            for (int s = 6; s < 16; s++) r[128*i + 8*s +: 8] = id;
        end
        return r;
    endfunction

    function automatic logic [127:0] beat_of(input logic [511:0] set, input int b);
        logic [127:0] r;
        for (int i = 0; i < LANES; i++) r[32*i +: 32] = set[128*i + 32*b +: 32];
        return r;
    endfunction

    // Drive one beat for one cycle (called at a negedge, returns at the next).
    task automatic beat(input logic [127:0] d, input logic [15:0] u, input logic last);
        s_axis_tdata  = d;
        s_axis_tuser  = u;
        s_axis_tlast  = last;
        s_axis_tkeep  = '1;
        s_axis_tvalid = 1'b1;
        @(negedge clk_i);
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
    endtask

    // Send beats 0..last_b of a set; pre = pulse state one cycle after the last beat.
    // For a full set, return one cycle later, when the classification pulse is visible.
    task automatic send_ts(input logic [511:0] set, input int last_b, input bit gap, output logic pre);
        for (int b = 0; b <= last_b; b++) begin
            beat(beat_of(set, b), (b == 0) ? 16'h1111 : 16'h0000, (b == last_b));
            if (gap && b < last_b) @(negedge clk_i);
        end
        pre = os_valid_o | os_err_o;
        if (last_b == 3) @(negedge clk_i);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1);
    end

    initial begin
        logic         pre;
        logic [511:0] ts_a;
        logic [511:0] ts_b;
        logic [511:0] bad;

        rst_n_i       = 1'b0;
        s_axis_tdata  = '0;
        s_axis_tkeep  = '0;
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        s_axis_tuser  = '0;
        repeat (3) @(negedge clk_i);

        chk("rst_tready", 512'(s_axis_tready), 512'(0));
        chk("rst_pulses", 512'({os_valid_o, ts1_det_o, ts2_det_o, eios_det_o, skp_det_o, os_err_o}), 512'(0));
        chk("rst_consec", 512'(consec_cnt_o), 512'(0));
        chk("rst_idle", 512'(idle_cnt_o), 512'(0));
        chk("rst_ts_lane", ts_lane_o, 512'(0));

        rst_n_i = 1'b1;
        @(negedge clk_i);
        chk("tready_up", 512'(s_axis_tready), 512'(1));

        // TS1 on four lanes: pulse exactly two cycles after beat 3.
        ts_a = mk_ts(8'h4A, 8'h10);
        send_ts(ts_a, 3, 1'b0, pre);
        chk("ts1_no_early", 512'(pre), 512'(0));
        chk("ts1_valid", 512'(os_valid_o), 512'(1));
        chk("ts1_det", 512'({ts1_det_o, ts2_det_o, os_err_o}), 512'(3'b100));
        chk("ts1_consec", 512'(consec_cnt_o), 512'(1));
        chk("ts1_lane_all", ts_lane_o, ts_a);
        chk("ts1_lane2_sym2", 512'(ts_lane_o[128*2 + 16 +: 8]), 512'(8'd2));
        @(negedge clk_i);
        chk("ts1_pulse_1cyc", 512'(os_valid_o), 512'(0));

        // Eight identical TS2 sets.
        ts_b = mk_ts(8'h45, 8'h10);
        for (int n = 1; n <= 8; n++) begin
            send_ts(ts_b, 3, 1'b0, pre);
            chk("ts2_det", 512'({ts1_det_o, ts2_det_o, os_err_o}), 512'(3'b010));
            chk("ts2_consec", 512'(consec_cnt_o), 512'(n));
        end
        ts_b = mk_ts(8'h45, 8'h20);
        send_ts(ts_b, 3, 1'b0, pre);
        chk("ts2_nfts_chg", 512'(consec_cnt_o), 512'(1));
        chk("ts2_lane_new", ts_lane_o, ts_b);

        // SKP and EIOS single-beat sets.
        beat({4{32'h1C1C1CBC}}, 16'hFFFF, 1'b1);
        chk("skp_det", 512'({os_valid_o, skp_det_o, eios_det_o, os_err_o}), 512'(4'b1100));
        chk("skp_consec", 512'(consec_cnt_o), 512'(1));
        @(negedge clk_i);
        chk("skp_1cyc", 512'(skp_det_o), 512'(0));
        beat({4{32'h7C7C7CBC}}, 16'hFFFF, 1'b1);
        chk("eios_det", 512'({os_valid_o, skp_det_o, eios_det_o, os_err_o}), 512'(4'b1010));
        chk("eios_consec", 512'(consec_cnt_o), 512'(1));
        chk("eios_ts_hold", ts_lane_o, ts_b);
        @(negedge clk_i);

        // Early tlast on beat 1.
        send_ts(ts_a, 1, 1'b0, pre);
        chk("early_last_err", 512'({os_err_o, os_valid_o}), 512'(2'b10));
        chk("early_last_consec", 512'(consec_cnt_o), 512'(0));
        @(negedge clk_i);

        // Good TS1, then a set whose lane 2 carries the TS2 identifier.
        send_ts(ts_a, 3, 1'b0, pre);
        chk("ts1_again_consec", 512'(consec_cnt_o), 512'(1));
        bad = ts_a;
        for (int s = 6; s < 16; s++) bad[128*2 + 8*s +: 8] = 8'h45;
        send_ts(bad, 3, 1'b0, pre);
        chk("mix_err", 512'({os_err_o, os_valid_o}), 512'(2'b10));
        chk("mix_consec", 512'(consec_cnt_o), 512'(0));
        chk("mix_ts_hold", ts_lane_o, ts_a);

        // Ten logical-IDLE beats back to back.
        for (int n = 0; n < 10; n++) beat('0, 16'h0000, 1'b0);
        chk("idle_cnt", 512'(idle_cnt_o), 512'(10));

        // TS1 with tvalid gaps between beats.
        send_ts(ts_a, 3, 1'b1, pre);
        chk("gap_ts1", 512'({ts1_det_o, os_err_o}), 512'(2'b10));
        chk("gap_consec", 512'(consec_cnt_o), 512'(1));
        chk("gap_idle_clr", 512'(idle_cnt_o), 512'(0));
        send_ts(ts_a, 3, 1'b1, pre);
        chk("gap_consec2", 512'(consec_cnt_o), 512'(2));

        // Reset asserted while beat 2 of a TS is on the bus.
        beat(beat_of(ts_a, 0), 16'h1111, 1'b0);
        beat(beat_of(ts_a, 1), 16'h0000, 1'b0);
        s_axis_tdata  = beat_of(ts_a, 2);
        s_axis_tuser  = '0;
        s_axis_tvalid = 1'b1;
        #1 rst_n_i = 1'b0;
        #1;
        chk("midrst_tready", 512'(s_axis_tready), 512'(0));
        chk("midrst_outs", 512'({os_valid_o, ts1_det_o, ts2_det_o, eios_det_o, skp_det_o, os_err_o,
                                consec_cnt_o, idle_cnt_o}), 512'(0));
        chk("midrst_ts_lane", ts_lane_o, 512'(0));
        @(negedge clk_i);
        s_axis_tvalid = 1'b0;
        @(negedge clk_i);
        rst_n_i = 1'b1;
        @(negedge clk_i);
        chk("midrst_no_pulse", 512'({os_valid_o, os_err_o}), 512'(0));
        send_ts(ts_a, 3, 1'b0, pre);
        chk("post_rst_ts1", 512'({ts1_det_o, os_err_o}), 512'(2'b10));
        chk("post_rst_consec", 512'(consec_cnt_o), 512'(1));
        chk("post_rst_lane", ts_lane_o, ts_a);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
